// File: rtl/picorv32_pkg.sv
// Shared decode constants and FSM state type for the compact RV32I core.
package picorv32_pkg;

    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    localparam logic [2:0] F3Add  = 3'b000;
    localparam logic [2:0] F3Sll  = 3'b001;
    localparam logic [2:0] F3Slt  = 3'b010;
    localparam logic [2:0] F3Sltu = 3'b011;
    localparam logic [2:0] F3Xor  = 3'b100;
    localparam logic [2:0] F3Srl  = 3'b101;
    localparam logic [2:0] F3Or   = 3'b110;
    localparam logic [2:0] F3And  = 3'b111;

    typedef enum logic [2:0] {
        StFetch,
        StExec,
        StLoad,
        StStore,
        StPcpi,
        StTrap
    } state_e;

endpackage

// File: rtl/picorv32_alu.sv
// Single-cycle RV32I ALU: arithmetic, logic, shifts and branch comparisons.
module picorv32_alu
    import picorv32_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  funct3_i,
    input  logic        alt_i,
    output logic [31:0] result_o,
    output logic        eq_o,
    output logic        lt_o,
    output logic        ltu_o
);

    assign eq_o  = (a_i == b_i);
    assign lt_o  = ($signed(a_i) < $signed(b_i));
    assign ltu_o = (a_i < b_i);

    always_comb begin
        result_o = 32'b0;
        unique case (funct3_i)
            F3Add:   result_o = alt_i ? (a_i - b_i) : (a_i + b_i);
            F3Sll:   result_o = a_i << b_i[4:0];
            F3Slt:   result_o = {31'b0, lt_o};
            F3Sltu:  result_o = {31'b0, ltu_o};
            F3Xor:   result_o = a_i ^ b_i;
            F3Srl:   result_o = alt_i ? 32'($signed(a_i) >>> b_i[4:0]) : (a_i >> b_i[4:0]);
            F3Or:    result_o = a_i | b_i;
            F3And:   result_o = a_i & b_i;
            default: result_o = 32'b0;
        endcase
    end

endmodule

// File: rtl/picorv32_core.sv
// Multi-cycle RV32I core with a PicoRV32-style native memory port and reduced PCPI.
module picorv32_core
    import picorv32_pkg::*;
#(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
`ifdef USE_POWER_PINS
    input  logic        vccd1,
    input  logic        vssd1,
`endif
    input  logic        clk,
    input  logic        resetn,
    output logic        trap,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        mem_la_read,
    output logic        mem_la_write,
    output logic [31:0] mem_la_addr,
    output logic [31:0] mem_la_wdata,
    output logic [3:0]  mem_la_wstrb,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready,
    input  logic [31:0] irq,
    output logic [31:0] eoi,
    output logic        trace_valid,
    output logic [35:0] trace_data
);

`ifdef USE_POWER_PINS
    logic unused_power;
    assign unused_power = vccd1 ^ vssd1;
`endif
    logic unused_irq;
    assign unused_irq = ^irq;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, insn_q, insn_d;
    logic        mem_valid_q, mem_instr_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic [1:0]  ea_lo_q, ea_lo_d;
    logic [3:0]  pcpi_cnt_q, pcpi_cnt_d;
    logic [31:0] regs [1:31];

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b, imm_u, imm_j, ea, target;
    logic [31:0] alu_b, alu_res, ld_val;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        alu_alt, alu_eq, alu_lt, alu_ltu, br_take, misaligned, jump;
    logic        rf_we;
    logic [31:0] rf_wd;
    logic        la_read, la_write;
    logic [31:0] la_addr, la_wdata;
    logic [3:0]  la_wstrb;

    assign opcode  = insn_q[6:0];
    assign funct3  = insn_q[14:12];
    assign rs1_val = (insn_q[19:15] == 5'd0) ? 32'b0 : regs[insn_q[19:15]];
    assign rs2_val = (insn_q[24:20] == 5'd0) ? 32'b0 : regs[insn_q[24:20]];
    assign imm_i   = {{20{insn_q[31]}}, insn_q[31:20]};
    assign imm_s   = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
    assign imm_b   = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
    assign imm_u   = {insn_q[31:12], 12'b0};
    assign imm_j   = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};
    assign ea      = rs1_val + ((opcode == OpcStore) ? imm_s : imm_i);

    // Halfword needs bit0 clear, word needs bits[1:0] clear; bytes are always aligned.
    assign misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                        ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

    assign alu_b   = (opcode == OpcOp) ? rs2_val : imm_i;
    assign alu_alt = (opcode == OpcOp) ? insn_q[30] : ((funct3 == F3Srl) && insn_q[30]);

    picorv32_alu u_alu (
        .a_i      (rs1_val),
        .b_i      (alu_b),
        .funct3_i (funct3),
        .alt_i    (alu_alt),
        .result_o (alu_res),
        .eq_o     (alu_eq),
        .lt_o     (alu_lt),
        .ltu_o    (alu_ltu)
    );

    always_comb begin
        case (funct3)
            F3Beq:   br_take = alu_eq;
            F3Bne:   br_take = !alu_eq;
            F3Blt:   br_take = alu_lt;
            F3Bge:   br_take = !alu_lt;
            F3Bltu:  br_take = alu_ltu;
            F3Bgeu:  br_take = !alu_ltu;
            default: br_take = 1'b0;
        endcase
    end

    assign ld_byte = mem_rdata[{ea_lo_q, 3'b000} +: 8];
    assign ld_half = ea_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        case (funct3)
            F3Lb:    ld_val = {{24{ld_byte[7]}}, ld_byte};
            F3Lh:    ld_val = {{16{ld_half[15]}}, ld_half};
            F3Lbu:   ld_val = {24'b0, ld_byte};
            F3Lhu:   ld_val = {16'b0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        insn_d     = insn_q;
        ea_lo_d    = ea_lo_q;
        pcpi_cnt_d = pcpi_cnt_q;
        rf_we      = 1'b0;
        rf_wd      = 32'b0;
        jump       = 1'b0;
        target     = pc_q + imm_b;
        la_read    = 1'b0;
        la_write   = 1'b0;
        la_addr    = 32'b0;
        la_wdata   = 32'b0;
        la_wstrb   = 4'b0;
        unique case (state_q)
            StFetch: begin
                if (!mem_valid_q) begin
                    la_read = 1'b1;
                    la_addr = pc_q;
                end else if (mem_ready) begin
                    insn_d  = mem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                pc_d    = pc_q + 32'd4;
                state_d = StFetch;
                case (opcode)
                    OpcLui:   begin rf_we = 1'b1; rf_wd = imm_u; end
                    OpcAuipc: begin rf_we = 1'b1; rf_wd = pc_q + imm_u; end
                    OpcJal: begin
                        rf_we  = 1'b1;
                        rf_wd  = pc_q + 32'd4;
                        jump   = 1'b1;
                        target = pc_q + imm_j;
                    end
                    OpcJalr: begin
                        rf_we  = 1'b1;
                        rf_wd  = pc_q + 32'd4;
                        jump   = 1'b1;
                        target = {ea[31:1], 1'b0};
                    end
                    OpcBranch: jump = br_take;
                    OpcLoad: begin
                        if (misaligned) begin
                            state_d = StTrap;
                        end else begin
                            state_d = StLoad;
                            ea_lo_d = ea[1:0];
                            la_read = 1'b1;
                            la_addr = {ea[31:2], 2'b00};
                        end
                    end
                    OpcStore: begin
                        if (misaligned) begin
                            state_d = StTrap;
                        end else begin
                            state_d  = StStore;
                            la_write = 1'b1;
                            la_addr  = {ea[31:2], 2'b00};
                            case (funct3[1:0])
                                2'b00: begin
                                    la_wdata = {4{rs2_val[7:0]}};
                                    la_wstrb = 4'b0001 << ea[1:0];
                                end
                                2'b01: begin
                                    la_wdata = {2{rs2_val[15:0]}};
                                    la_wstrb = ea[1] ? 4'b1100 : 4'b0011;
                                end
                                default: begin
                                    la_wdata = rs2_val;
                                    la_wstrb = 4'b1111;
                                end
                            endcase
                        end
                    end
                    OpcOpImm, OpcOp: begin rf_we = 1'b1; rf_wd = alu_res; end
                    OpcMiscMem: ;
                    OpcSystem: state_d = StTrap;
                    default: begin
                        state_d    = StPcpi;
                        pc_d       = pc_q;
                        pcpi_cnt_d = 4'd0;
                    end
                endcase
                if (jump) begin
                    if (target[1]) state_d = StTrap;
                    else           pc_d    = target;
                end
            end
            StLoad: begin
                if (mem_valid_q && mem_ready) begin
                    rf_we   = 1'b1;
                    rf_wd   = ld_val;
                    state_d = StFetch;
                end
            end
            StStore: begin
                if (mem_valid_q && mem_ready) state_d = StFetch;
            end
            StPcpi: begin
                if (pcpi_ready) begin
                    rf_we   = pcpi_wr;
                    rf_wd   = pcpi_rd;
                    pc_d    = pc_q + 32'd4;
                    state_d = StFetch;
                end else if (!pcpi_wait) begin
                    if (pcpi_cnt_q == 4'd15) state_d = StTrap;
                    else                     pcpi_cnt_d = pcpi_cnt_q + 4'd1;
                end
            end
            StTrap: ;
            default: state_d = StTrap;
        endcase
        // Every return to FETCH launches the next instruction fetch on the same edge.
        if (state_d == StFetch && state_q != StFetch) begin
            la_read = 1'b1;
            la_addr = pc_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StFetch;
            pc_q        <= PROGADDR_RESET;
            insn_q      <= 32'b0;
            ea_lo_q     <= 2'b0;
            pcpi_cnt_q  <= 4'b0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= 32'b0;
            mem_wdata_q <= 32'b0;
            mem_wstrb_q <= 4'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            insn_q     <= insn_d;
            ea_lo_q    <= ea_lo_d;
            pcpi_cnt_q <= pcpi_cnt_d;
            if (la_read || la_write) begin
                mem_valid_q <= 1'b1;
                mem_instr_q <= (state_d == StFetch);
                mem_addr_q  <= la_addr;
                mem_wdata_q <= la_wdata;
                mem_wstrb_q <= la_wstrb;
            end else if (mem_valid_q && mem_ready) begin
                mem_valid_q <= 1'b0;
                mem_instr_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we && insn_q[11:7] != 5'd0 && state_d != StTrap) regs[insn_q[11:7]] <= rf_wd;
    end

    assign trap         = (state_q == StTrap);
    assign mem_valid    = mem_valid_q;
    assign mem_instr    = mem_instr_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;
    assign mem_la_read  = la_read;
    assign mem_la_write = la_write;
    assign mem_la_addr  = la_addr;
    assign mem_la_wdata = la_wdata;
    assign mem_la_wstrb = la_wstrb;
    assign pcpi_valid   = (state_q == StPcpi);
    assign pcpi_insn    = insn_q;
    assign pcpi_rs1     = rs1_val;
    assign pcpi_rs2     = rs2_val;
    assign eoi          = 32'b0;
    assign trace_valid  = 1'b0;
    assign trace_data   = 36'b0;

endmodule

// File: tb/tb_picorv32_core.sv
// Scoreboard bench for picorv32_core: directed programs, expected memory transactions queued.
module tb_picorv32_core;

    typedef struct packed {
        logic        wr;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } txn_t;

    logic        clk, resetn, trap;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_la_read, mem_la_write;
    logic [31:0] mem_la_addr, mem_la_wdata;
    logic [3:0]  mem_la_wstrb;
    logic        pcpi_valid, pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2, pcpi_rd;
    logic [31:0] irq, eoi;
    logic        trace_valid;
    logic [35:0] trace_data;

    logic [31:0] mem [0:255];
    txn_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    picorv32_core #(.PROGADDR_RESET(32'h0000_0000)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .trap         (trap),
        .mem_valid    (mem_valid),
        .mem_instr    (mem_instr),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .mem_la_read  (mem_la_read),
        .mem_la_write (mem_la_write),
        .mem_la_addr  (mem_la_addr),
        .mem_la_wdata (mem_la_wdata),
        .mem_la_wstrb (mem_la_wstrb),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .pcpi_wait    (pcpi_wait),
        .pcpi_ready   (pcpi_ready),
        .irq          (irq),
        .eoi          (eoi),
        .trace_valid  (trace_valid),
        .trace_data   (trace_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic ok, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_f(input logic [31:0] a);
        exp_q.push_back('{wr: 1'b0, instr: 1'b1, addr: a, wdata: 32'b0, wstrb: 4'b0});
    endtask

    task automatic push_r(input logic [31:0] a);
        exp_q.push_back('{wr: 1'b0, instr: 1'b0, addr: a, wdata: 32'b0, wstrb: 4'b0});
    endtask

    task automatic push_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_q.push_back('{wr: 1'b1, instr: 1'b0, addr: a, wdata: d, wstrb: s});
    endtask

    // Memory responder and monitor: acks one cycle after mem_valid, checking each request.
    initial begin
        txn_t e;
        mem_ready = 1'b0;
        mem_rdata = 32'b0;
        forever begin
            @(negedge clk);
            if (!resetn || mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_txn: got addr=%h wstrb=%b instr=%b, expected none",
                             mem_addr, mem_wstrb, mem_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr == e.addr && mem_wstrb == e.wstrb && mem_instr == e.instr &&
                        (!e.wr || mem_wdata == e.wdata))
                        n_pass++;
                    else
                        $display("FAIL txn: got addr=%h wdata=%h wstrb=%b instr=%b, expected addr=%h wdata=%h wstrb=%b instr=%b",
                                 mem_addr, mem_wdata, mem_wstrb, mem_instr,
                                 e.addr, e.wdata, e.wstrb, e.instr);
                end
                for (int b = 0; b < 4; b++)
                    if (mem_wstrb[b]) mem[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                mem_rdata = mem[mem_addr[9:2]];
                mem_ready = 1'b1;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
        exp_q.delete();
    endtask

    task automatic wait_trap(input int bound, input string name);
        int n = 0;
        while (!trap && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, trap == 1'b1, {31'b0, trap}, 32'd1);
    endtask

    task automatic quiet(input int cycles, input string name);
        int bad = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (mem_valid || mem_la_read || mem_la_write || !trap) bad++;
        end
        check(name, bad == 0, bad, 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        pcpi_wr = 1'b0; pcpi_rd = 32'b0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        irq = 32'b0;

        // Program A: byte store, signed/unsigned loads, branches, jal, ALU ops, ebreak.
        clear_mem();
        mem[0]  = 32'h04800093;  // addi x1,x0,0x48
        mem[1]  = 32'h10100023;  // sb   x1,0x100(x0)
        mem[2]  = 32'h20000213;  // addi x4,x0,0x200
        mem[3]  = 32'h00020103;  // lb   x2,0(x4)
        mem[4]  = 32'h00024183;  // lbu  x3,0(x4)
        mem[5]  = 32'h10202023;  // sw   x2,0x100(x0)
        mem[6]  = 32'h10302023;  // sw   x3,0x100(x0)
        mem[7]  = 32'h00000463;  // beq  x0,x0,+8
        mem[8]  = 32'h10002023;  // sw   x0 (skipped)
        mem[9]  = 32'h00001463;  // bne  x0,x0,+8
        mem[10] = 32'h10101123;  // sh   x1,0x102(x0)
        mem[11] = 32'h00C000EF;  // jal  x1,+12
        mem[12] = 32'h10002023;  // skipped
        mem[13] = 32'h10002023;  // skipped
        mem[14] = 32'h10102023;  // sw   x1,0x100(x0)
        mem[15] = 32'h800002B7;  // lui  x5,0x80000
        mem[16] = 32'h4042D313;  // srai x6,x5,4
        mem[17] = 32'h10602023;  // sw   x6,0x100(x0)
        mem[18] = 32'h401003B3;  // sub  x7,x0,x1
        mem[19] = 32'h10702023;  // sw   x7,0x100(x0)
        mem[20] = 32'h0003A433;  // slt  x8,x7,x0
        mem[21] = 32'h10802023;  // sw   x8,0x100(x0)
        mem[22] = 32'h00100073;  // ebreak
        mem[128] = 32'h00000080;
        push_f(32'h00); push_f(32'h04); push_w(32'h100, 32'h48484848, 4'b0001);
        push_f(32'h08); push_f(32'h0C); push_r(32'h200);
        push_f(32'h10); push_r(32'h200);
        push_f(32'h14); push_w(32'h100, 32'hFFFFFF80, 4'b1111);
        push_f(32'h18); push_w(32'h100, 32'h00000080, 4'b1111);
        push_f(32'h1C); push_f(32'h24); push_f(32'h28);
        push_w(32'h100, 32'h00480048, 4'b1100);
        push_f(32'h2C); push_f(32'h38); push_w(32'h100, 32'h00000030, 4'b1111);
        push_f(32'h3C); push_f(32'h40); push_f(32'h44);
        push_w(32'h100, 32'hF8000000, 4'b1111);
        push_f(32'h48); push_f(32'h4C); push_w(32'h100, 32'hFFFFFFD0, 4'b1111);
        push_f(32'h50); push_f(32'h54); push_w(32'h100, 32'h00000001, 4'b1111);
        push_f(32'h58);

        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", mem_valid == 1'b0, {31'b0, mem_valid}, 32'd0);
        check("rst_mem_addr", mem_addr == 32'b0, mem_addr, 32'd0);
        check("rst_mem_wstrb", mem_wstrb == 4'b0, {28'b0, mem_wstrb}, 32'd0);
        check("rst_trap", trap == 1'b0, {31'b0, trap}, 32'd0);
        check("rst_pcpi_valid", pcpi_valid == 1'b0, {31'b0, pcpi_valid}, 32'd0);
        check("rst_mem_instr", mem_instr == 1'b0, {31'b0, mem_instr}, 32'd0);
        release_reset();
        #1;
        check("la_read_first", mem_la_read == 1'b1, {31'b0, mem_la_read}, 32'd1);
        check("la_addr_first", mem_la_addr == 32'b0, mem_la_addr, 32'd0);
        @(posedge clk);
        #1;
        check("first_valid", mem_valid == 1'b1, {31'b0, mem_valid}, 32'd1);
        check("first_instr", mem_instr == 1'b1, {31'b0, mem_instr}, 32'd1);
        check("first_addr", mem_addr == 32'b0, mem_addr, 32'd0);
        wait_trap(500, "ebreak_trap");
        check("progA_drain", exp_q.size() == 0, exp_q.size(), 32'd0);
        quiet(100, "ebreak_quiet");

        // Program B: misaligned lw traps without any data request.
        resetn = 1'b0;
        clear_mem();
        mem[0] = 32'h10202083;  // lw x1,0x102(x0)
        push_f(32'h00);
        release_reset();
        wait_trap(50, "mis_lw_trap");
        check("progB_drain", exp_q.size() == 0, exp_q.size(), 32'd0);
        quiet(20, "mis_lw_quiet");

        // Program C: reset pulse while a store request is pending.
        resetn = 1'b0;
        clear_mem();
        mem[0] = 32'h10002023;  // sw x0,0x100(x0)
        mem[1] = 32'h00100073;  // ebreak
        push_f(32'h00);
        release_reset();
        n = 0;
        while (!(mem_valid && mem_wstrb != 4'b0) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("store_pending", mem_valid && mem_wstrb == 4'b1111, {28'b0, mem_wstrb}, 32'hF);
        resetn = 1'b0;
        #1;
        check("async_rst_valid", mem_valid == 1'b0, {31'b0, mem_valid}, 32'd0);
        check("async_rst_wstrb", mem_wstrb == 4'b0, {28'b0, mem_wstrb}, 32'd0);
        check("progC_pre_drain", exp_q.size() == 0, exp_q.size(), 32'd0);
        push_f(32'h00); push_w(32'h100, 32'h0, 4'b1111); push_f(32'h04);
        release_reset();
        wait_trap(50, "progC_trap");
        check("progC_drain", exp_q.size() == 0, exp_q.size(), 32'd0);

        // Program D: unknown opcode with no coprocessor answers times out into trap.
        resetn = 1'b0;
        clear_mem();
        mem[0] = 32'h0000000B;
        push_f(32'h00);
        release_reset();
        n = 0;
        for (int i = 0; i < 60 && !trap; i++) begin
            @(posedge clk);
            #1;
            if (pcpi_valid) begin
                n++;
                if (n == 1) check("pcpi_insn", pcpi_insn == 32'h0000000B, pcpi_insn, 32'hB);
            end
        end
        check("pcpi_timeout_trap", trap == 1'b1, {31'b0, trap}, 32'd1);
        check("pcpi_valid_cycles", n == 16, n, 32'd16);
        check("progD_drain", exp_q.size() == 0, exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
